// File: rtl/bus_poll_scheduler.sv
// rtl/bus_poll_scheduler.sv - serial bus polling master with check-byte validation and alarm hold
module bus_poll_scheduler #(
  parameter logic [7:0]  KEY        = 8'h37,
  parameter logic [7:0]  SLAVE_BASE = 8'h01,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] slot_mask,
  input  logic       rx,
  output logic       tx,
  input  logic       alarm_ack,
  output logic       result_valid,
  output logic [7:0] result_data,
  output logic [1:0] result_slot,
  output logic       alarm,
  output logic [1:0] alarm_slot,
  output logic       timeout_err,
  output logic       check_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT    = 3'd2,
    S_RECV    = 3'd3,
    S_CHECK   = 3'd4,
    S_PUBLISH = 3'd5,
    S_GAP     = 3'd6,
    S_ALARM   = 3'd7
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        result_valid_q, result_valid_d;
  logic [7:0]  result_data_q, result_data_d;
  logic [1:0]  result_slot_q, result_slot_d;
  logic        alarm_q, alarm_d;
  logic [1:0]  alarm_slot_q, alarm_slot_d;
  logic        timeout_err_q, timeout_err_d;
  logic        check_err_q, check_err_d;

  logic [7:0]  addr;
  logic [7:0]  rx_data;
  logic [7:0]  rx_check;
  logic [2:0]  bit_idx;

  assign addr     = SLAVE_BASE + {6'd0, slot_q};
  assign rx_data  = shift_q[7:0];
  assign rx_check = shift_q[15:8];

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    result_valid_d = 1'b0;
    result_data_d  = result_data_q;
    result_slot_d  = result_slot_q;
    alarm_d        = alarm_q;
    alarm_slot_d   = alarm_slot_q;
    timeout_err_d  = 1'b0;
    check_err_d    = 1'b0;
    tx_d           = 1'b1;
    bit_idx        = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          if (slot_mask[slot_q]) begin
            state_d = S_SEND;
            cnt_d   = 8'd0;
          end else if (slot_mask != 4'd0) begin
            slot_d = slot_q + 2'd1;
          end
        end
      end
      S_SEND: begin
        if (cnt_q == 8'd8) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        // The low cycle is the response start bit; data begins on the next cycle.
        if (!rx) begin
          state_d = S_RECV;
          cnt_d   = 8'd0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = S_GAP;
          cnt_d         = 8'd0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RECV: begin
        shift_d = {rx, shift_q[15:1]};
        if (cnt_q == 8'd15) begin
          state_d = S_CHECK;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CHECK: begin
        if (rx_data == 8'h00 && rx_check == KEY) begin
          state_d      = S_ALARM;
          alarm_d      = 1'b1;
          alarm_slot_d = slot_q;
        end else if (rx_check == KEY) begin
          state_d        = S_PUBLISH;
          result_valid_d = 1'b1;
          result_data_d  = rx_data;
          result_slot_d  = slot_q;
        end else begin
          state_d     = S_GAP;
          check_err_d = 1'b1;
        end
      end
      S_PUBLISH: begin
        state_d = S_GAP;
      end
      S_ALARM: begin
        if (alarm_ack) begin
          state_d = S_GAP;
          alarm_d = 1'b0;
        end
      end
      S_GAP: begin
        slot_d  = slot_q + 2'd1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // tx is registered, so it is computed from the next state to stay aligned with it.
    if (state_d == S_SEND) begin
      bit_idx = 3'(cnt_d - 8'd1);
      tx_d    = (cnt_d == 8'd0) ? 1'b0 : addr[bit_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      slot_q         <= 2'd0;
      cnt_q          <= 8'd0;
      shift_q        <= 16'd0;
      tx_q           <= 1'b1;
      result_valid_q <= 1'b0;
      result_data_q  <= 8'd0;
      result_slot_q  <= 2'd0;
      alarm_q        <= 1'b0;
      alarm_slot_q   <= 2'd0;
      timeout_err_q  <= 1'b0;
      check_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      tx_q           <= tx_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      result_slot_q  <= result_slot_d;
      alarm_q        <= alarm_d;
      alarm_slot_q   <= alarm_slot_d;
      timeout_err_q  <= timeout_err_d;
      check_err_q    <= check_err_d;
    end
  end

  assign tx           = tx_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign result_slot  = result_slot_q;
  assign alarm        = alarm_q;
  assign alarm_slot   = alarm_slot_q;
  assign timeout_err  = timeout_err_q;
  assign check_err    = check_err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_bus_poll_scheduler.sv
// tb/tb_bus_poll_scheduler.sv - scoreboard bench for bus_poll_scheduler with a serial slave model
module tb_bus_poll_scheduler;
  localparam logic [7:0] KEY  = 8'h37;
  localparam logic [7:0] BASE = 8'h01;
  localparam int         TMO  = 64;

  localparam logic [3:0] K_RES = 4'b1000;
  localparam logic [3:0] K_TMO = 4'b0100;
  localparam logic [3:0] K_CHK = 4'b0010;
  localparam logic [3:0] K_ALM = 4'b0001;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable = 1'b0;
  logic [3:0] slot_mask = 4'd0;
  logic       rx = 1'b1;
  logic       alarm_ack = 1'b0;
  logic       tx;
  logic       result_valid;
  logic [7:0] result_data;
  logic [1:0] result_slot;
  logic       alarm;
  logic [1:0] alarm_slot;
  logic       timeout_err;
  logic       check_err;
  logic [2:0] state;

  bus_poll_scheduler #(.KEY(KEY), .SLAVE_BASE(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .slot_mask(slot_mask), .rx(rx), .tx(tx),
    .alarm_ack(alarm_ack), .result_valid(result_valid), .result_data(result_data),
    .result_slot(result_slot), .alarm(alarm), .alarm_slot(alarm_slot),
    .timeout_err(timeout_err), .check_err(check_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] kind;
    logic [1:0] slot;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  frames_done = 0;
  int  tx_viol = 0;
  logic force_good = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic wait_frames(input int n);
    int budget;
    budget = 20000;
    while (frames_done < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (frames_done < n) begin
      checks++;
      errors++;
      $display("FAIL wait_frames: got %0d transactions expected %0d", frames_done, n);
      summary();
    end
  endtask

  task automatic settle_idle(input string name);
    repeat (10) @(negedge clk);
    chk(name, state, 3'd0);
    chk({name, "_tx"}, tx, 1'b1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a transaction outcome.
  initial begin : monitor
    logic       alarm_prev;
    logic [7:0] last_pub;
    logic [3:0] seen;
    ev_t        e;
    alarm_prev = 1'b0;
    last_pub   = 8'd0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        alarm_prev = 1'b0;
        last_pub   = 8'd0;
      end else begin
        if (state != 3'd1 && tx !== 1'b1) tx_viol++;
        seen = {result_valid, timeout_err, check_err, alarm && !alarm_prev};
        if (seen != 4'd0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got outcome %b expected none", seen);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", seen, e.kind);
            if (e.kind == K_RES) begin
              chk("result_data", result_data, e.data);
              chk("result_slot", result_slot, e.slot);
              last_pub = e.data;
            end else begin
              chk("result_data_held", result_data, last_pub);
              if (e.kind == K_ALM) chk("alarm_slot", alarm_slot, e.slot);
            end
          end
        end
        alarm_prev = alarm;
      end
    end
  end

  // Slave model: decodes each address frame, predicts the slot, answers and queues the outcome.
  int exp_slot = 0;
  initial begin : slave
    logic [7:0]  addr;
    logic [7:0]  ea;
    logic [7:0]  d;
    logic [7:0]  c;
    logic [15:0] frame;
    int          s;
    int          w;
    int          idx;
    int          bad;
    bit          aborted;
    bit          spur;
    ev_t         e;
    idx = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        exp_slot = 0;
      end else if (tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          addr[i] = tx;
        end
        s = -1;
        for (int k = 0; k < 4; k++)
          if (s < 0 && slot_mask[(exp_slot + k) % 4]) s = (exp_slot + k) % 4;
        if (s < 0) begin
          checks++;
          errors++;
          $display("FAIL send_with_empty_mask: got address %0h expected no transaction", addr);
          s = 0;
        end
        ea = BASE + 8'(s);
        chk("send_addr", addr, ea);
        exp_slot = (s + 1) % 4;

        spur = 1'b0;
        case (idx)
          0: begin w = 3;       d = 8'hA5; c = KEY;   end
          1: begin w = TMO;     d = 8'h00; c = 8'h00; end
          2: begin w = 0;       d = 8'h12; c = 8'h36; end
          3: begin w = TMO - 1; d = 8'h81; c = KEY;   end
          4, 5: begin w = $urandom_range(0, 10); d = 8'($urandom_range(1, 255)); c = KEY; end
          6: begin w = 5;       d = 8'h00; c = KEY;   end
          7: begin w = 1;       d = 8'h5A; c = KEY;   end
          default: begin
            if (force_good) begin
              w = 2; d = 8'h3C; c = KEY;
            end else begin
              spur = 1'b1;
              w = ($urandom % 8 == 0) ? TMO : $urandom_range(0, TMO - 1);
              d = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
              c = ($urandom % 4 == 0) ? 8'($urandom) : KEY;
            end
          end
        endcase
        idx++;

        e.slot = 2'(s);
        e.data = d;
        if (w >= TMO) begin
          e.kind = K_TMO;
          exp_q.push_back(e);
          for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            alarm_ack = spur && ($urandom % 4 == 0);
          end
          alarm_ack = 1'b0;
          chk("timeout_not_early", timeout_err, 1'b0);
          @(negedge clk);
          chk("timeout_at_limit", timeout_err, 1'b1);
        end else begin
          for (int k = 0; k < w; k++) begin
            @(negedge clk);
            alarm_ack = spur && ($urandom % 4 == 0);
          end
          @(negedge clk);
          alarm_ack = 1'b0;
          rx = 1'b0;
          frame = {c, d};
          aborted = 1'b0;
          for (int i = 0; i < 16 && !aborted; i++) begin
            @(negedge clk);
            if (reset !== 1'b1) aborted = 1'b1;
            else rx = frame[i];
          end
          if (!aborted) begin
            @(negedge clk);
            if (reset !== 1'b1) aborted = 1'b1;
          end
          rx = 1'b1;
          if (aborted) begin
            exp_slot = 0;
          end else begin
            e.kind = (d == 8'h00 && c == KEY) ? K_ALM : (c == KEY) ? K_RES : K_CHK;
            exp_q.push_back(e);
            if (e.kind == K_ALM) begin
              @(negedge clk);
              chk("alarm_set", alarm, 1'b1);
              bad = 0;
              repeat (100) begin
                @(negedge clk);
                if (tx !== 1'b1 || state !== 3'd7 || alarm !== 1'b1) bad++;
              end
              chk("alarm_hold", bad, 0);
              alarm_ack = 1'b1;
              @(negedge clk);
              chk("alarm_cleared", alarm, 1'b0);
              alarm_ack = 1'b0;
            end
          end
        end
        frames_done++;
      end
    end
  end

  initial begin : main
    int bad;
    int target;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_tx", tx, 1'b1);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_result_data", result_data, 8'd0);
    chk("rst_alarm", alarm, 1'b0);
    chk("rst_pulses", {timeout_err, check_err}, 2'b00);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_without_enable", state, 3'd0);

    slot_mask = 4'b0001; enable = 1'b1;
    wait_frames(3); enable = 1'b0;
    settle_idle("idle_after_disable_a");

    slot_mask = 4'b1010; enable = 1'b1;
    wait_frames(6); enable = 1'b0;
    settle_idle("idle_after_disable_b");

    slot_mask = 4'b1100; enable = 1'b1;
    wait_frames(8); enable = 1'b0;
    settle_idle("idle_after_disable_c");

    slot_mask = 4'b0000; enable = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (state !== 3'd0 || tx !== 1'b1) bad++;
    end
    chk("mask_zero_idle", bad, 0);
    enable = 1'b0;

    for (int chunk = 0; chunk < 4; chunk++) begin
      slot_mask = 4'($urandom_range(1, 15));
      enable = 1'b1;
      wait_frames(8 + 25 * (chunk + 1));
      enable = 1'b0;
      settle_idle("idle_after_random");
    end

    force_good = 1'b1;
    slot_mask = 4'b1111;
    enable = 1'b1;
    bad = 0;
    while (state !== 3'd3 && bad < 500) begin
      @(negedge clk);
      bad++;
    end
    chk("reached_recv", state, 3'd3);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    #1;
    chk("abort_state", state, 3'd0);
    chk("abort_tx", tx, 1'b1);
    chk("abort_outputs", {result_valid, result_data, result_slot, alarm, alarm_slot, timeout_err, check_err}, 16'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_after_abort", state, 3'd0);

    target = frames_done + 2;
    enable = 1'b1;
    wait_frames(target);
    enable = 1'b0;
    settle_idle("idle_final");
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("tx_high_outside_send", tx_viol, 0);
    summary();
  end
endmodule
